// File: rtl/sessao_votos_if.sv
// Voter-side bus of the voting-session controller: session start, per-voter
// request/vote/grant lanes and the tally results.
interface sessao_votos_if;
  logic       inicio;
  logic [2:0] req;
  logic [2:0] voto;
  logic [2:0] ack;
  logic [2:0] V;
  logic [2:0] votou;
  logic       ocupado;
  logic       pronto;
  logic [1:0] contagem;
  logic       aprovado;
  logic       timeout;

  modport master (
    output inicio, req, voto,
    input  ack, V, votou, ocupado, pronto, contagem, aprovado, timeout
  );

  modport slave (
    input  inicio, req, voto,
    output ack, V, votou, ocupado, pronto, contagem, aprovado, timeout
  );
endinterface

// File: rtl/sessao_votos.sv
// Three-voter session controller: round-robin vote collection with a
// collection-window timer, followed by a one-cycle tally of the ballot vector.
module sessao_votos #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned W_TMO   = 8
) (
  input logic           clk,
  input logic           rst,
  sessao_votos_if.slave bus
);
  typedef enum logic [1:0] {OCIOSO, COLETA, APURA} state_e;

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [W_TMO-1:0] timer_q, timer_d;
  logic [2:0]       ack_q, ack_d;
  logic [2:0]       v_q, v_d;
  logic [2:0]       votou_q, votou_d;
  logic [1:0]       contagem_q, contagem_d;
  logic             ocupado_q, ocupado_d;
  logic             pronto_q, pronto_d;
  logic             aprovado_q, aprovado_d;
  logic             timeout_q, timeout_d;

  logic [2:0] elig;
  logic [2:0] gnt;
  logic       last_tick;

  // A voter that already voted drops out of arbitration even if req lingers.
  assign elig      = bus.req & ~votou_q;
  assign last_tick = (timer_q == W_TMO'(TIMEOUT - 1));

  always_comb begin
    gnt = 3'b000;
    case (ptr_q)
      2'd1: begin
        if      (elig[1]) gnt = 3'b010;
        else if (elig[2]) gnt = 3'b100;
        else if (elig[0]) gnt = 3'b001;
      end
      2'd2: begin
        if      (elig[2]) gnt = 3'b100;
        else if (elig[0]) gnt = 3'b001;
        else if (elig[1]) gnt = 3'b010;
      end
      default: begin
        if      (elig[0]) gnt = 3'b001;
        else if (elig[1]) gnt = 3'b010;
        else if (elig[2]) gnt = 3'b100;
      end
    endcase
  end

  always_comb begin
    // NOTE: every _d gets a hold/default value first so no path infers a latch.
    state_d    = state_q;
    ptr_d      = ptr_q;
    timer_d    = timer_q;
    ack_d      = 3'b000;
    v_d        = v_q;
    votou_d    = votou_q;
    contagem_d = contagem_q;
    aprovado_d = aprovado_q;
    timeout_d  = timeout_q;

    case (state_q)
      OCIOSO: begin
        if (bus.inicio) begin
          state_d    = COLETA;
          ptr_d      = 2'd0;
          timer_d    = '0;
          v_d        = 3'b000;
          votou_d    = 3'b000;
          contagem_d = 2'd0;
          aprovado_d = 1'b0;
          timeout_d  = 1'b0;
        end
      end
      COLETA: begin
        timer_d = timer_q + W_TMO'(1);
        ack_d   = gnt;
        v_d     = (v_q & ~gnt) | (bus.voto & gnt);
        votou_d = votou_q | gnt;
        if      (gnt[0]) ptr_d = 2'd1;
        else if (gnt[1]) ptr_d = 2'd2;
        else if (gnt[2]) ptr_d = 2'd0;
        // A grant on the final timer cycle still counts before timeout is judged.
        if (votou_d == 3'b111 || last_tick) begin
          state_d   = APURA;
          timeout_d = (votou_d != 3'b111);
        end
      end
      APURA: begin
        contagem_d = 2'(v_q[0]) + 2'(v_q[1]) + 2'(v_q[2]);
        aprovado_d = contagem_d[1];
        state_d    = OCIOSO;
      end
      default: state_d = OCIOSO;
    endcase

    ocupado_d = (state_d != OCIOSO);
    pronto_d  = (state_q == APURA);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments only.
    if (rst) begin
      state_q    <= OCIOSO;
      ptr_q      <= 2'd0;
      timer_q    <= '0;
      ack_q      <= 3'b000;
      v_q        <= 3'b000;
      votou_q    <= 3'b000;
      contagem_q <= 2'd0;
      ocupado_q  <= 1'b0;
      pronto_q   <= 1'b0;
      aprovado_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      timer_q    <= timer_d;
      ack_q      <= ack_d;
      v_q        <= v_d;
      votou_q    <= votou_d;
      contagem_q <= contagem_d;
      ocupado_q  <= ocupado_d;
      pronto_q   <= pronto_d;
      aprovado_q <= aprovado_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.V        = v_q;
  assign bus.votou    = votou_q;
  assign bus.contagem = contagem_q;
  assign bus.ocupado  = ocupado_q;
  assign bus.pronto   = pronto_q;
  assign bus.aprovado = aprovado_q;
  assign bus.timeout  = timeout_q;
endmodule

// File: tb/tb_sessao_votos.sv
// Directed bench for sessao_votos: expected grants and tally results are queued
// as stimulus is driven and matched, with their cycle, when the DUT emits them.
module tb_sessao_votos;
  localparam int TIMEOUT = 15;

  typedef struct {
    int         cyc;
    logic [2:0] val;
  } ack_exp_t;

  typedef struct {
    int         cyc;
    logic [2:0] v;
    logic [2:0] votou;
    logic [1:0] cont;
    logic       aprov;
    logic       tmo;
  } res_exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   c0;

  ack_exp_t ack_sb[$];
  res_exp_t res_sb[$];

  sessao_votos_if bus ();

  sessao_votos #(.TIMEOUT(TIMEOUT), .W_TMO(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  task automatic exp_ack(input int c, input logic [2:0] val);
    ack_exp_t e;
    e.cyc = c;
    e.val = val;
    ack_sb.push_back(e);
  endtask

  task automatic exp_res(input int c, input logic [2:0] v, input logic [2:0] votou,
                         input logic [1:0] cont, input logic aprov, input logic tmo);
    res_exp_t e;
    e.cyc   = c;
    e.v     = v;
    e.votou = votou;
    e.cont  = cont;
    e.aprov = aprov;
    e.tmo   = tmo;
    res_sb.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((ack_sb.size() != 0 || res_sb.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check("drain_ack", ack_sb.size(), 0);
    check("drain_res", res_sb.size(), 0);
    ack_sb.delete();
    res_sb.delete();
    step();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ack"}, bus.ack, 3'b000);
    check({tag, "_V"}, bus.V, 3'b000);
    check({tag, "_votou"}, bus.votou, 3'b000);
    check({tag, "_ocupado"}, bus.ocupado, 1'b0);
    check({tag, "_pronto"}, bus.pronto, 1'b0);
    check({tag, "_contagem"}, bus.contagem, 2'd0);
    check({tag, "_aprovado"}, bus.aprovado, 1'b0);
    check({tag, "_timeout"}, bus.timeout, 1'b0);
  endtask

  // Output monitor: every ack and pronto must match the head of its queue.
  always @(negedge clk) begin
    if (!rst && bus.ack !== 3'b000) begin
      if (ack_sb.size() == 0) begin
        check("ack_unexpected", bus.ack, 3'b000);
      end else begin
        ack_exp_t e;
        e = ack_sb.pop_front();
        check("ack_value", bus.ack, e.val);
        check("ack_cycle", cyc, e.cyc);
      end
    end
    if (!rst && bus.pronto !== 1'b0) begin
      if (res_sb.size() == 0) begin
        check("pronto_unexpected", bus.pronto, 1'b0);
      end else begin
        res_exp_t e;
        e = res_sb.pop_front();
        check("pronto_cycle", cyc, e.cyc);
        check("res_V", bus.V, e.v);
        check("res_votou", bus.votou, e.votou);
        check("res_contagem", bus.contagem, e.cont);
        check("res_aprovado", bus.aprovado, e.aprov);
        check("res_timeout", bus.timeout, e.tmo);
        check("res_ocupado", bus.ocupado, 1'b0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no completion expected summary before time limit");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    rst        = 1'b1;
    bus.inicio = 1'b0;
    bus.req    = 3'b000;
    bus.voto   = 3'b000;
    step();
    step();
    rst = 1'b0;
    step();
    check_idle("reset");

    // Full session at minimum latency, voto = 101.
    c0 = cyc;
    bus.inicio = 1'b1;
    exp_ack(c0 + 2, 3'b001);
    exp_ack(c0 + 3, 3'b010);
    exp_ack(c0 + 4, 3'b100);
    exp_res(c0 + 5, 3'b101, 3'b111, 2'd2, 1'b1, 1'b0);
    step();
    bus.inicio = 1'b0;
    bus.req    = 3'b111;
    bus.voto   = 3'b101;
    check("t1_ocupado", bus.ocupado, 1'b1);
    goto(c0 + 5);
    bus.req = 3'b000;
    drain(10);

    // Only voter 1 votes; session closes on the timer.
    c0 = cyc;
    bus.inicio = 1'b1;
    exp_ack(c0 + 2, 3'b010);
    exp_res(c0 + TIMEOUT + 2, 3'b010, 3'b010, 2'd1, 1'b0, 1'b1);
    step();
    bus.inicio = 1'b0;
    bus.req    = 3'b010;
    bus.voto   = 3'b010;
    check("t2_clear_contagem", bus.contagem, 2'd0);
    check("t2_clear_aprovado", bus.aprovado, 1'b0);
    check("t2_clear_V", bus.V, 3'b000);
    check("t2_clear_votou", bus.votou, 3'b000);
    goto(c0 + 2);
    bus.req = 3'b000;
    drain(30);

    // Voter 1 holds req after its grant; voters 2 and 0 join later.
    c0 = cyc;
    bus.inicio = 1'b1;
    exp_ack(c0 + 2, 3'b010);
    exp_ack(c0 + 5, 3'b100);
    exp_ack(c0 + 6, 3'b001);
    exp_res(c0 + 7, 3'b111, 3'b111, 2'd3, 1'b1, 1'b0);
    step();
    bus.inicio = 1'b0;
    bus.req    = 3'b010;
    bus.voto   = 3'b111;
    check("t3_clear_timeout", bus.timeout, 1'b0);
    goto(c0 + 4);
    bus.req = 3'b111;
    goto(c0 + 7);
    bus.req = 3'b000;
    drain(10);

    // req while idle and inicio during COLETA/APURA are ignored.
    bus.req  = 3'b111;
    bus.voto = 3'b111;
    step();
    step();
    bus.req = 3'b000;
    step();
    c0 = cyc;
    bus.inicio = 1'b1;
    exp_ack(c0 + 2, 3'b001);
    exp_res(c0 + TIMEOUT + 2, 3'b001, 3'b001, 2'd1, 1'b0, 1'b1);
    step();
    bus.inicio = 1'b0;
    bus.req    = 3'b001;
    bus.voto   = 3'b001;
    goto(c0 + 2);
    bus.req = 3'b000;
    goto(c0 + 5);
    bus.inicio = 1'b1;
    step();
    bus.inicio = 1'b0;
    goto(c0 + 10);
    bus.inicio = 1'b1;
    step();
    bus.inicio = 1'b0;
    goto(c0 + TIMEOUT + 1);
    bus.inicio = 1'b1;
    step();
    bus.inicio = 1'b0;
    drain(10);

    // Voter 2 votes in the last timer cycle: accepted, no timeout.
    c0 = cyc;
    bus.inicio = 1'b1;
    exp_ack(c0 + 2, 3'b001);
    exp_ack(c0 + 3, 3'b010);
    exp_ack(c0 + TIMEOUT + 1, 3'b100);
    exp_res(c0 + TIMEOUT + 2, 3'b110, 3'b111, 2'd2, 1'b1, 1'b0);
    step();
    bus.inicio = 1'b0;
    bus.req    = 3'b011;
    bus.voto   = 3'b110;
    goto(c0 + 3);
    bus.req = 3'b000;
    goto(c0 + TIMEOUT);
    bus.req = 3'b100;
    step();
    bus.req = 3'b000;
    drain(10);

    // Reset mid-session aborts it without a pronto.
    c0 = cyc;
    bus.inicio = 1'b1;
    exp_ack(c0 + 2, 3'b001);
    step();
    bus.inicio = 1'b0;
    bus.req    = 3'b001;
    bus.voto   = 3'b001;
    goto(c0 + 3);
    bus.req = 3'b000;
    rst     = 1'b1;
    step();
    rst = 1'b0;
    check_idle("abort");
    for (int k = 0; k < 20; k++) step();
    drain(1);

    c0 = cyc;
    bus.inicio = 1'b1;
    exp_ack(c0 + 2, 3'b001);
    exp_ack(c0 + 3, 3'b010);
    exp_ack(c0 + 4, 3'b100);
    exp_res(c0 + 5, 3'b011, 3'b111, 2'd2, 1'b1, 1'b0);
    step();
    bus.inicio = 1'b0;
    bus.req    = 3'b111;
    bus.voto   = 3'b011;
    goto(c0 + 5);
    bus.req = 3'b000;
    drain(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
